alu_share_ctrl: RTL and testbench

- Round-robin scheduler that shares one N-bit ALU (add, sub, AND, OR) between NUM_REQ requesters.
- Each requester presents an operation over a valid/ready handshake. The controller captures the winning request, drives the shared ALU, registers result and flags, and returns them with the requester ID over a valid/ready response channel.
- Sits between the sequencing logic and the arithmetic datapath.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_dut.sv | 44 ++++
 rtl/rr_pick.sv | 52 +++++
 rtl/alu_share_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share controller: opcodes and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // True for opcodes whose overflow flag is meaningful.
  function automatic logic op_is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_dut.sv
// Combinational N-bit ALU: add, sub, AND, OR with signed overflow.
module alu_dut
  import alu_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] i_a,
  input  logic [data_width-1:0] i_b,
  input  logic [1:0]            i_op,
  output logic [data_width-1:0] o_r,
  output logic                  o_ov
);

  localparam int MSB = data_width - 1;

  // Result and two's-complement overflow for the selected operation.
  always_comb begin
    o_r  = '0;
    o_ov = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_r  = i_a + i_b;
        o_ov = (i_a[MSB] == i_b[MSB]) && (o_r[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        o_r  = i_a - i_b;
        o_ov = (i_a[MSB] != i_b[MSB]) && (o_r[MSB] != i_a[MSB]);
      end
      OP_AND: begin
        o_r  = i_a & i_b;
        o_ov = 1'b0;
      end
      OP_OR: begin
        o_r  = i_a | i_b;
        o_ov = 1'b0;
      end
      default: begin
        o_r  = '0;
        o_ov = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first valid bit at or above the pointer, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // Distance from the pointer is computed per requester so every vector
  // index stays a loop constant; the smallest distance among valid bits wins.
  logic [ID_W:0] w_best;
  logic [ID_W:0] w_dist;

  // Select the valid requester closest to the pointer (modulo NUM_REQ).
  always_comb begin
    w_best = (ID_W+1)'(NUM_REQ);
    w_dist = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((ID_W+1)'(i) >= {1'b0, i_ptr}) begin
        w_dist = (ID_W+1)'(i) - {1'b0, i_ptr};
      end else begin
        w_dist = (ID_W+1)'(i) + (ID_W+1)'(NUM_REQ) - {1'b0, i_ptr};
      end
      if (i_valid[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = ID_W'(i);
        o_any  = 1'b1;
      end else begin
        w_best = w_best;
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (o_any && (o_idx == ID_W'(i))) begin
        o_gnt[i] = 1'b1;
      end else begin
        o_gnt[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one ALU between NUM_REQ requesters.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [2*NUM_REQ-1:0]          req_op,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_r,
  output logic                          rsp_ov,
  output logic                          rsp_sign,
  output logic                          rsp_zero,
  output logic                          busy
);

  state_t                r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [1:0]            r_op;
  logic [ID_W-1:0]       r_id;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_r;
  logic                  r_rsp_ov;
  logic                  r_rsp_sign;
  logic                  r_rsp_zero;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]       w_idx;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_alu_r;
  logic                  w_alu_ov;
  logic [ID_W-1:0]       w_next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  alu_dut #(
    .data_width (DATA_WIDTH)
  ) u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_r  (w_alu_r),
    .o_ov (w_alu_ov)
  );

  // Accept strobe exists only while idle and out of reset, so it is
  // one-hot or zero and silent while the datapath is occupied.
  always_comb begin
    if ((r_state == ST_IDLE) && rst_n) begin
      req_ready = w_gnt;
    end else begin
      req_ready = '0;
    end
  end

  // Pointer moves to the requester just after the one last served.
  always_comb begin
    if (r_rsp_id == ID_W'(NUM_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = r_rsp_id + ID_W'(1);
    end
  end

  // Controller FSM: capture winner, execute, hold response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 2'b00;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_r     <= '0;
      r_rsp_ov    <= 1'b0;
      r_rsp_sign  <= 1'b0;
      r_rsp_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_a     <= req_a[w_idx*DATA_WIDTH +: DATA_WIDTH];
            r_b     <= req_b[w_idx*DATA_WIDTH +: DATA_WIDTH];
            r_op    <= req_op[w_idx*2 +: 2];
            r_id    <= w_idx;
            r_state <= ST_EXEC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_rsp_r     <= w_alu_r;
          r_rsp_ov    <= op_is_arith(r_op) ? w_alu_ov : 1'b0;
          r_rsp_sign  <= w_alu_r[DATA_WIDTH-1];
          r_rsp_zero  <= ~|w_alu_r;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_RESP;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_r     = r_rsp_r;
  assign rsp_ov    = r_rsp_ov;
  assign rsp_sign  = r_rsp_sign;
  assign rsp_zero  = r_rsp_zero;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl.
module tb_alu_share_ctrl;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [2*NR-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_r;
  logic              rsp_ov;
  logic              rsp_sign;
  logic              rsp_zero;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  alu_share_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_W       (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r),
    .rsp_ov    (rsp_ov),
    .rsp_sign  (rsp_sign),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_op[i*2 +: 2]  = op;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [15:0] r,
                         input logic ov, input logic sg, input logic zr);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"},    {30'd0, rsp_id},    {30'd0, id});
    chk({tag, "_r"},     {16'd0, rsp_r},     {16'd0, r});
    chk({tag, "_ov"},    {31'd0, rsp_ov},    {31'd0, ov});
    chk({tag, "_sign"},  {31'd0, rsp_sign},  {31'd0, sg});
    chk({tag, "_zero"},  {31'd0, rsp_zero},  {31'd0, zr});
  endtask

  logic [15:0] rr_r  [4];
  logic        rr_ov [4];
  logic        rr_sg [4];
  logic        rr_zr [4];
  logic [3:0]  onehot;

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    rr_r[0] = 16'h7FFF; rr_ov[0] = 1'b1; rr_sg[0] = 1'b0; rr_zr[0] = 1'b0;
    rr_r[1] = 16'h0000; rr_ov[1] = 1'b1; rr_sg[1] = 1'b0; rr_zr[1] = 1'b1;
    rr_r[2] = 16'h8000; rr_ov[2] = 1'b0; rr_sg[2] = 1'b1; rr_zr[2] = 1'b0;
    rr_r[3] = 16'h0000; rr_ov[3] = 1'b0; rr_sg[3] = 1'b0; rr_zr[3] = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_id",    {30'd0, rsp_id},    32'd0);
    chk("rst_r",     {16'd0, rsp_r},     32'd0);
    chk("rst_flags", {29'd0, rsp_ov, rsp_sign, rsp_zero}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    step();

    // Single add with overflow from req0
    set_req(0, 16'h7FFF, 16'h0001, 2'b00);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("add_ready", {28'd0, req_ready}, 32'h1);
    chk("add_busy0", {31'd0, busy}, 32'd0);
    step();
    req_valid = 4'b0000;
    #1;
    chk("add_exec_ready", {28'd0, req_ready}, 32'd0);
    chk("add_exec_busy",  {31'd0, busy}, 32'd1);
    chk("add_exec_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk_rsp("add", 2'd0, 16'h8000, 1'b1, 1'b1, 1'b0);
    step();
    chk("add_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_done_busy",  {31'd0, busy}, 32'd0);
    chk("add_done_hold",  {16'd0, rsp_r}, 32'h8000);

    // Sub to zero from req2 (pointer now 1)
    set_req(2, 16'h1234, 16'h1234, 2'b01);
    req_valid = 4'b0100;
    #1;
    chk("sub_ready", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = 4'b0000;
    step();
    chk_rsp("sub", 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1);
    step();

    // Picker wrap: pointer 3, only req0 valid
    set_req(0, 16'h1200, 16'h0034, 2'b11);
    req_valid = 4'b0001;
    #1;
    chk("wrap0_ready", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    step();
    chk_rsp("or", 2'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
    step();

    // Pointer 1, only req3 valid; AND with 10 cycles of backpressure
    set_req(3, 16'hF0F0, 16'h0FF0, 2'b10);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    #1;
    chk("wrap3_ready", {28'd0, req_ready}, 32'h8);
    step();
    req_valid = 4'b1111;
    #1;
    chk("bp_exec_ready", {28'd0, req_ready}, 32'd0);
    step();
    for (int k = 0; k < 10; k++) begin
      chk_rsp("bp", 2'd3, 16'h00F0, 1'b0, 1'b0, 1'b0);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      step();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
    step();
    chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_done_hold",  {16'd0, rsp_r}, 32'h00F0);

    // Round robin, all valid, pointer 0: grants 0,1,2,3,0 every 3 cycles
    set_req(0, 16'h8000, 16'h0001, 2'b01);
    set_req(1, 16'h8000, 16'h8000, 2'b00);
    set_req(2, 16'hFFFF, 16'h8000, 2'b10);
    set_req(3, 16'h0000, 16'h0000, 2'b11);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      onehot = 4'b0001 << (k % 4);
      chk("rr_ready", {28'd0, req_ready}, {28'd0, onehot});
      step();
      chk("rr_exec_ready", {28'd0, req_ready}, 32'd0);
      chk("rr_exec_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      chk_rsp("rr", 2'(k % 4), rr_r[k % 4], rr_ov[k % 4], rr_sg[k % 4], rr_zr[k % 4]);
      step();
    end
    req_valid = 4'b0000;

    // Reset during EXEC (pointer 1 before reset)
    set_req(1, 16'h0001, 16'h0001, 2'b00);
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", {28'd0, req_ready}, 32'h2);
    step();
    req_valid = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_r",     {16'd0, rsp_r}, 32'd0);
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    req_valid = 4'b1001;
    #1;
    chk("post_rst_ready", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    step();
    chk_rsp("post_rst", 2'd0, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    step();
    chk("post_rst_done", {31'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
